pipe_load_ctrl: RTL and testbench

PIPE_LOAD_CTRL -- requirements
Module: pipe_load_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 9 +
 rtl/pipe_stage_ctrl.sv | 20 ++
 rtl/pipe_load_ctrl.sv | 72 +++++++
 tb/tb_pipe_load_ctrl.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared defaults and occupancy width helper for the pipeline load controller.
package pipe_ctrl_pkg;
    localparam int DEF_PIPELINE_STAGE = 5;
    localparam int DEF_CNT_WIDTH      = 32;

    function automatic int occ_width(input int n);
        return $clog2(n + 1);
    endfunction
endpackage

// File: rtl/pipe_stage_ctrl.sv
// pipe_stage_ctrl: valid/accept/load control for one pipeline stage.
module pipe_stage_ctrl (
    input  logic clk,
    input  logic rstn,
    input  logic flush,
    input  logic src_valid,
    input  logic down_take,
    output logic load,
    output logic valid
);
    logic drain;

    assign drain = valid && down_take;
    assign load  = src_valid && (!valid || drain) && !flush && rstn;

    always_ff @(posedge clk)
        if (!rstn || flush) valid <= 1'b0;
        else if (load)      valid <= 1'b1;
        else if (drain)     valid <= 1'b0;
endmodule

// File: rtl/pipe_load_ctrl.sv
// pipe_load_ctrl: bubble-collapsing per-stage load enables with occupancy tracking.
// Define PIPE_LOAD_CTRL_STATS_EN to build the saturating stall/transfer counters.
module pipe_load_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int PIPELINE_STAGE = DEF_PIPELINE_STAGE,
    parameter int CNT_WIDTH      = DEF_CNT_WIDTH
) (
    input  logic                                   sys_clk,
    input  logic                                   rstn,
    input  logic                                   in_valid_i,
    output logic                                   in_ready_o,
    output logic                                   out_valid_o,
    input  logic                                   out_ready_i,
    input  logic                                   flush_i,
    output logic [PIPELINE_STAGE-1:0]              pipeLoad_en_o,
    output logic [PIPELINE_STAGE-1:0]              stage_valid_o,
    output logic [occ_width(PIPELINE_STAGE)-1:0]   occupancy_o,
    output logic [CNT_WIDTH-1:0]                   stall_cnt_o,
    output logic [CNT_WIDTH-1:0]                   xfer_cnt_o
);
    localparam int OW = occ_width(PIPELINE_STAGE);

    logic [PIPELINE_STAGE-1:0] src_valid;
    logic [PIPELINE_STAGE-1:0] down_take;
    logic                      out_hs;

    // down_take[k] is the load of stage k+1, so ready ripples back combinationally
    for (genvar k = 0; k < PIPELINE_STAGE; k++) begin : g_stage
        if (k == 0) begin : g_src_in
            assign src_valid[k] = in_valid_i;
        end else begin : g_src_prev
            assign src_valid[k] = stage_valid_o[k-1];
        end
        if (k == PIPELINE_STAGE - 1) begin : g_take_out
            assign down_take[k] = out_ready_i;
        end else begin : g_take_next
            assign down_take[k] = pipeLoad_en_o[k+1];
        end
        pipe_stage_ctrl u_stage (
            .clk       (sys_clk),
            .rstn      (rstn),
            .flush     (flush_i),
            .src_valid (src_valid[k]),
            .down_take (down_take[k]),
            .load      (pipeLoad_en_o[k]),
            .valid     (stage_valid_o[k])
        );
    end

    assign in_ready_o  = (!stage_valid_o[0] || down_take[0]) && !flush_i && rstn;
    assign out_valid_o = stage_valid_o[PIPELINE_STAGE-1];
    assign out_hs      = out_valid_o && out_ready_i;

    always_ff @(posedge sys_clk)
        if (!rstn || flush_i) occupancy_o <= '0;
        else                  occupancy_o <= occupancy_o + OW'(pipeLoad_en_o[0]) - OW'(out_hs);

`ifdef PIPE_LOAD_CTRL_STATS_EN
    always_ff @(posedge sys_clk)
        if (!rstn) begin
            stall_cnt_o <= '0;
            xfer_cnt_o  <= '0;
        end else begin
            if (out_valid_o && !out_ready_i && !(&stall_cnt_o)) stall_cnt_o <= stall_cnt_o + 1'b1;
            if (out_hs && !(&xfer_cnt_o))                       xfer_cnt_o  <= xfer_cnt_o + 1'b1;
        end
`else
    assign stall_cnt_o = '0;
    assign xfer_cnt_o  = '0;
`endif
endmodule

// File: tb/tb_pipe_load_ctrl.sv
// tb_pipe_load_ctrl: directed self-checking bench for pipe_load_ctrl with five stages.
module tb_pipe_load_ctrl;
    logic        sys_clk = 1'b0;
    logic        rstn, in_valid, in_ready, out_valid, out_ready, flush;
    logic [4:0]  load_en, stage_valid;
    logic [2:0]  occupancy;
    logic [31:0] stall_cnt, xfer_cnt;
    int          checks = 0;
    int          errors = 0;

`ifdef PIPE_LOAD_CTRL_STATS_EN
    localparam logic [31:0] EXP_STALL = 32'd10;
    localparam logic [31:0] EXP_XFER  = 32'd1;
`else
    localparam logic [31:0] EXP_STALL = 32'd0;
    localparam logic [31:0] EXP_XFER  = 32'd0;
`endif

    always #5 sys_clk = ~sys_clk;

    pipe_load_ctrl #(.PIPELINE_STAGE(5), .CNT_WIDTH(32)) dut (
        .sys_clk       (sys_clk),
        .rstn          (rstn),
        .in_valid_i    (in_valid),
        .in_ready_o    (in_ready),
        .out_valid_o   (out_valid),
        .out_ready_i   (out_ready),
        .flush_i       (flush),
        .pipeLoad_en_o (load_en),
        .stage_valid_o (stage_valid),
        .occupancy_o   (occupancy),
        .stall_cnt_o   (stall_cnt),
        .xfer_cnt_o    (xfer_cnt)
    );

    task automatic do_reset();
        rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        @(negedge sys_clk);
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        rstn = 1'b0; in_valid = 1'b1; out_ready = 1'b1; flush = 1'b0;
        #1;
        checks++; if (load_en !== 5'b0) begin errors++; $display("FAIL rst_load got %b exp 00000", load_en); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b exp 0", in_ready); end
        @(negedge sys_clk);
        checks++; if (stage_valid !== 5'b0) begin errors++; $display("FAIL rst_valid got %b exp 00000", stage_valid); end
        checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL rst_occ got %0d exp 0", occupancy); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
        checks++; if (stall_cnt !== 32'd0 || xfer_cnt !== 32'd0) begin errors++; $display("FAIL rst_cnt got %0d/%0d exp 0/0", stall_cnt, xfer_cnt); end
        rstn = 1'b1; in_valid = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rel_in_ready got %b exp 1", in_ready); end
        @(negedge sys_clk);
    endtask

    task automatic test_single();
        do_reset();
        out_ready = 1'b1;
        for (int c = 0; c <= 6; c++) begin
            in_valid = (c == 0);
            #1;
            checks++; if (load_en !== ((c < 5) ? 5'(1 << c) : 5'b0)) begin errors++; $display("FAIL single_load c%0d got %b exp %b", c, load_en, (c < 5) ? 5'(1 << c) : 5'b0); end
            checks++; if (out_valid !== (c == 5)) begin errors++; $display("FAIL single_out_valid c%0d got %b exp %b", c, out_valid, c == 5); end
            @(negedge sys_clk);
        end
    endtask

    task automatic test_fill();
        do_reset();
        in_valid = 1'b1; out_ready = 1'b0;
        for (int c = 0; c <= 5; c++) begin
            #1;
            checks++; if (in_ready !== (c < 5)) begin errors++; $display("FAIL fill_in_ready c%0d got %b exp %b", c, in_ready, c < 5); end
            checks++; if (occupancy !== 3'(c)) begin errors++; $display("FAIL fill_occ c%0d got %0d exp %0d", c, occupancy, c); end
            @(negedge sys_clk);
        end
        #1;
        checks++; if (load_en !== 5'b0) begin errors++; $display("FAIL fill_load got %b exp 00000", load_en); end
        checks++; if (stage_valid !== 5'b11111) begin errors++; $display("FAIL fill_valid got %b exp 11111", stage_valid); end
    endtask

    task automatic test_full_thru();
        out_ready = 1'b1; in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (load_en !== 5'b11111) begin errors++; $display("FAIL thru_load c%0d got %b exp 11111", c, load_en); end
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL thru_in_ready c%0d got %b exp 1", c, in_ready); end
            @(negedge sys_clk);
            checks++; if (occupancy !== 3'd5) begin errors++; $display("FAIL thru_occ c%0d got %0d exp 5", c, occupancy); end
        end
    endtask

    task automatic test_reset_mid();
        rstn = 1'b0;
        #1;
        checks++; if (load_en !== 5'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL midrst_load got %b/%b exp 00000/0", load_en, in_ready); end
        @(negedge sys_clk);
        checks++; if (stage_valid !== 5'b0 || occupancy !== 3'd0) begin errors++; $display("FAIL midrst_state got %b/%0d exp 00000/0", stage_valid, occupancy); end
        checks++; if (xfer_cnt !== 32'd0) begin errors++; $display("FAIL midrst_xfer got %0d exp 0", xfer_cnt); end
        rstn = 1'b1;
    endtask

    task automatic test_compact();
        do_reset();
        out_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            in_valid = (c == 0 || c == 3);
            @(negedge sys_clk);
        end
        in_valid = 1'b0;
        #1;
        checks++; if (stage_valid !== 5'b11000) begin errors++; $display("FAIL compact_valid got %b exp 11000", stage_valid); end
        checks++; if (occupancy !== 3'd2) begin errors++; $display("FAIL compact_occ got %0d exp 2", occupancy); end
        checks++; if (load_en !== 5'b0) begin errors++; $display("FAIL compact_load got %b exp 00000", load_en); end
    endtask

    task automatic test_flush();
        do_reset();
        out_ready = 1'b0; in_valid = 1'b1;
        repeat (3) @(negedge sys_clk);
        in_valid = 1'b1; flush = 1'b1;
        #1;
        checks++; if (occupancy !== 3'd3) begin errors++; $display("FAIL flush_pre_occ got %0d exp 3", occupancy); end
        checks++; if (stage_valid !== 5'b00111) begin errors++; $display("FAIL flush_pre_valid got %b exp 00111", stage_valid); end
        checks++; if (load_en !== 5'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL flush_load got %b/%b exp 00000/0", load_en, in_ready); end
        @(negedge sys_clk);
        flush = 1'b0; in_valid = 1'b0;
        #1;
        checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL flush_occ got %0d exp 0", occupancy); end
        checks++; if (stage_valid !== 5'b0) begin errors++; $display("FAIL flush_valid got %b exp 00000", stage_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready got %b exp 1", in_ready); end
        @(negedge sys_clk);
    endtask

    task automatic test_stats();
        do_reset();
        for (int c = 0; c <= 15; c++) begin
            in_valid  = (c == 0);
            out_ready = (c == 15);
            #1;
            if (c == 5) begin
                checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stats_latency got %b exp 1", out_valid); end
            end
            @(negedge sys_clk);
        end
        out_ready = 1'b0;
        #1;
        checks++; if (stall_cnt !== EXP_STALL) begin errors++; $display("FAIL stats_stall got %0d exp %0d", stall_cnt, EXP_STALL); end
        checks++; if (xfer_cnt !== EXP_XFER) begin errors++; $display("FAIL stats_xfer got %0d exp %0d", xfer_cnt, EXP_XFER); end
        checks++; if (out_valid !== 1'b0 || occupancy !== 3'd0) begin errors++; $display("FAIL stats_drained got %b/%0d exp 0/0", out_valid, occupancy); end
        @(negedge sys_clk);
    endtask

    initial begin
        rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        @(negedge sys_clk);
        test_reset();
        test_single();
        test_fill();
        test_full_thru();
        test_reset_mid();
        test_compact();
        test_flush();
        test_stats();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
